inst_stream_loader: RTL and testbench

- Parametrised successor to the byte-wide instruction write path used to preload the RISC core's instruction memory.
- Accepts a stream of bytes over a valid/ready handshake and assembles them into WORD_W-bit instruction words.
- Writes the words to consecutive instruction-memory addresses starting at a programmable base, and holds the CPU in reset for the duration of the load.
- Reports completion, address-range errors and an XOR checksum of all accepted bytes.

---
 rtl/inst_stream_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_stream_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_stream_loader.sv
// =============================================================================
// Module   : inst_stream_loader
// Brief    : Byte-stream instruction-memory preloader; holds the CPU in reset
//            while assembling bytes into words and writing them to memory.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module inst_stream_loader #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int LITTLE_END = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(NB - 1);
    localparam logic [ADDR_W+1:0] c_depth    = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remain;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_word;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic [7:0]          r_checksum;

    logic                w_start_ok;
    logic                w_accept;
    logic                w_last_byte;
    logic                w_range_err;
    logic [ADDR_W+1:0]   w_end;
    logic [IDX_W-1:0]    w_lane;
    logic [WORD_W-1:0]   w_word_next;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERROR));
    // abort wins over a byte offered in the same cycle
    assign w_accept    = (r_state == S_COLLECT) && byte_valid && !abort;
    assign w_last_byte = w_accept && (r_idx == c_last_idx);

    assign w_end       = {2'b00, base_addr} + {1'b0, word_count};
    assign w_range_err = (w_end > c_depth);

    assign w_lane = (LITTLE_END != 0) ? r_idx : (c_last_idx - r_idx);

    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < NB; i++) begin
            if (w_lane == IDX_W'(i)) begin
                w_word_next[8*i +: 8] = byte_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (w_range_err) begin
                        w_state_next = S_ERROR;
                    end else if (word_count == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = (r_remain == (ADDR_W+1)'(1)) ? S_DONE : S_COLLECT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_checksum  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_addr     <= base_addr;
                r_remain   <= word_count;
                r_idx      <= '0;
                r_checksum <= '0;
            end
            if (w_accept) begin
                r_word     <= w_word_next;
                r_checksum <= r_checksum ^ byte_in;
                r_idx      <= w_last_byte ? '0 : (r_idx + IDX_W'(1));
            end
            // Write port registers are loaded one cycle early so they are valid in WRITE
            if (w_last_byte) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word_next;
            end
            if (r_state == S_WRITE) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - (ADDR_W+1)'(1);
            end
        end
    end

    assign byte_ready = (r_state == S_COLLECT);
    assign mem_we     = (r_state == S_WRITE);
    assign busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign cpu_hold   = busy;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERROR);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign checksum   = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_inst_stream_loader.sv
// =============================================================================
// Module   : tb_inst_stream_loader
// Brief    : Scoreboard bench for inst_stream_loader with a word-level model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_inst_stream_loader;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 7;
    localparam int LITTLE_END = 1;
    localparam int NB         = WORD_W / 8;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        checksum;

    inst_stream_loader #(
        .WORD_W     (WORD_W),
        .ADDR_W     (ADDR_W),
        .LITTLE_END (LITTLE_END)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         errors = 0;
    int         checks = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
                check("wr_hold", 64'(cpu_hold), 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        foreach (stim[i]) x ^= stim[i];
        return x;
    endfunction

    task automatic model_push(int base, int count);
        logic [WORD_W-1:0] d;
        int sh;
        for (int w = 0; w < count; w++) begin
            d = '0;
            for (int k = 0; k < NB; k++) begin
                sh = (LITTLE_END != 0) ? 8 * k : 8 * (NB - 1 - k);
                d  = d | (WORD_W'(stim[w*NB+k]) << sh);
            end
            exp_q.push_back('{addr: ADDR_W'(base + w), data: d});
        end
    endtask

    task automatic fill_random(int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    task automatic do_start(int base, int count);
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W+1)'(count);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        if (base + count > DEPTH) begin
            check("err_flag", 64'(error), 64'd1);
            check("err_idle", 64'({busy, cpu_hold, byte_ready, done}), 64'd0);
        end else if (count == 0) begin
            check("zero_done", 64'(done), 64'd1);
            check("zero_csum", 64'(checksum), 64'd0);
            check("zero_idle", 64'({busy, cpu_hold, error}), 64'd0);
        end else begin
            check("start_busy", 64'({busy, cpu_hold, byte_ready}), 64'b111);
            model_push(base, count);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic send_stream(int first, int last, int gap, bit rnd);
        int g;
        for (int i = first; i < last; i++) begin
            send_byte(stim[i]);
            g = rnd ? int'($urandom_range(0, gap)) : gap;
            for (int j = 0; j < g; j++) begin
                if (((i + 1) % NB) != 0) check("gap_ready", 64'(byte_ready), 64'd1);
                tick();
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("done", 64'(done), 64'd1);
        check("csum", 64'(checksum), 64'(model_xor()));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("release", 64'({busy, cpu_hold, byte_ready, error}), 64'd0);
    endtask

    task automatic load(int base, int count, int gap, bit rnd);
        do_start(base, count);
        if (count > 0 && base + count <= DEPTH) begin
            send_stream(0, count * NB, gap, rnd);
            wait_done();
        end
    endtask

    initial begin
        int cnt;
        int bas;
        start      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        base_addr  = '0;
        word_count = '0;
        rst        = 1'b1;

        // Reset with noisy inputs
        repeat (2) begin
            start      = 1'($urandom);
            abort      = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_in    = 8'($urandom);
            base_addr  = ADDR_W'($urandom);
            word_count = (ADDR_W+1)'($urandom);
            tick();
        end
        check("reset_outputs", 64'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold,
                                    busy, done, error, checksum}), 64'd0);
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        tick();

        // Known stream, back-to-back then sparse
        stim = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(5, 2, 0, 1'b0);
        check("csum_known", 64'(checksum), 64'h24);
        load(5, 2, 2, 1'b0);
        check("csum_sparse", 64'(checksum), 64'h24);

        // Range overflow then the last legal window
        do_start(126, 3);
        tick();
        check("err_hold", 64'(error), 64'd1);
        fill_random(2 * NB);
        load(126, 2, 1, 1'b1);

        // Empty session
        stim.delete();
        load(9, 0, 0, 1'b0);

        // Abort after two bytes of a word
        fill_random(NB);
        do_start(10, 1);
        send_stream(0, 2, 0, 1'b0);
        abort      = 1'b1;
        byte_in    = stim[2];
        byte_valid = 1'b1;
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        exp_q.delete();
        check("abort_idle", 64'({busy, cpu_hold, byte_ready, done, error}), 64'd0);
        check("abort_csum", 64'(checksum), 64'(stim[0] ^ stim[1]));
        repeat (6) tick();

        // start pulse mid-collection must not disturb the session
        fill_random(NB);
        do_start(20, 1);
        send_stream(0, 2, 0, 1'b0);
        base_addr  = ADDR_W'(40);
        word_count = (ADDR_W+1)'(3);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("start_ignored", 64'({busy, byte_ready}), 64'b11);
        send_stream(2, NB, 0, 1'b0);
        wait_done();

        // Random legal sessions and a random overflow
        repeat (6) begin
            cnt = int'($urandom_range(1, 4));
            bas = int'($urandom_range(0, DEPTH - cnt));
            fill_random(cnt * NB);
            load(bas, cnt, 3, 1'b1);
        end
        cnt = int'($urandom_range(2, 8));
        bas = DEPTH - cnt + int'($urandom_range(1, cnt - 1));
        do_start(bas, cnt);
        repeat (3) tick();

        // Reset asserted during a WRITE cycle
        fill_random(3 * NB);
        do_start(50, 3);
        send_stream(0, NB, 0, 1'b0);
        check("write_cycle", 64'(mem_we), 64'd1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("rst_in_write", 64'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold,
                                   busy, done, error, checksum}), 64'd0);
        rst = 1'b0;
        repeat (10) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        check("post_rst_idle", 64'({busy, byte_ready, done}), 64'd0);

        // Recovery session
        fill_random(NB);
        load(0, 1, 1, 1'b1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
